arb_merge_2to1: RTL and testbench



---
 rtl/arb_merge_2to1_pkg.sv | 20 ++
 rtl/arb_merge_2to1_fifo.sv | 58 +++++
 rtl/arb_merge_2to1.sv | 168 ++++++++++++++++
 tb/tb_arb_merge_2to1.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_merge_2to1_pkg.sv
// Shared definitions for the 2:1 arbitrated merge: grant encoding,
// request-bus bit positions and the control FSM state encoding.
package arb_merge_2to1_pkg;

  // Grant encoding returned by the external arbiter
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // Bit positions inside the request bus
  localparam int REQ_A_IDX = 0;
  localparam int REQ_B_IDX = 1;

  // Request/grant/pop control sequence
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_POP      = 2'd2
  } state_t;

endpackage

// File: rtl/arb_merge_2to1_fifo.sv
// sync_fifo_simple: small first-word-fall-through FIFO used as the per-stream
// input buffer. The head entry is visible on rd_data whenever !empty, so a
// pop can be captured by the consumer's register in the same cycle.
module sync_fifo_simple #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  push;
  logic                  pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign rd_data = mem[rd_ptr_reg];

  // Storage array; contents need no reset because the occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/arb_merge_2to1.sv
// arb_merge_2to1: buffers two input streams, requests the shared link from an
// external last-served arbiter, and forwards the granted beat through a
// registered output stage. Optional beat counters are enabled by defining
// ARB_MERGE_STATS_EN.
module arb_merge_2to1
  import arb_merge_2to1_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic                  i_valid_a,
  output logic                  o_ready_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_valid_b,
  output logic                  o_ready_b,
  output logic [1:0]            o_req_bus,
  output logic                  o_req_valid,
  input  logic                  i_grant_b,
  input  logic                  i_grant_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef ARB_MERGE_STATS_EN
  ,
  output logic [15:0]           o_cnt_a,
  output logic [15:0]           o_cnt_b
`endif
);

  // Per-stream buffer signals, indexed by request-bus position
  logic [DATA_WIDTH-1:0] fifo_wdata [2];
  logic [DATA_WIDTH-1:0] fifo_rdata [2];
  logic [1:0]            fifo_push;
  logic [1:0]            fifo_pop;
  logic [1:0]            fifo_full;
  logic [1:0]            fifo_empty;

  state_t                state_reg, state_next;
  logic                  gnt_sel_reg, gnt_sel_next;
  logic                  pop_sel;
  logic                  pop_en;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] o_data_reg;
  logic                  o_valid_reg;

  assign fifo_wdata[REQ_A_IDX] = i_data_a;
  assign fifo_wdata[REQ_B_IDX] = i_data_b;
  assign fifo_push[REQ_A_IDX]  = i_valid_a;
  assign fifo_push[REQ_B_IDX]  = i_valid_b;
  assign o_ready_a             = !fifo_full[REQ_A_IDX];
  assign o_ready_b             = !fifo_full[REQ_B_IDX];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      sync_fifo_simple #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push[gi]),
        .wr_data (fifo_wdata[gi]),
        .rd_en   (fifo_pop[gi]),
        .rd_data (fifo_rdata[gi]),
        .full    (fifo_full[gi]),
        .empty   (fifo_empty[gi])
      );
    end
  endgenerate

  assign out_free = !o_valid_reg || i_ready;

  // A stale grant (granted buffer already empty) falls back to the other side
  always_comb begin
    pop_sel = gnt_sel_reg;
    if (gnt_sel_reg == GNT_A && fifo_empty[REQ_A_IDX]) pop_sel = GNT_B;
    if (gnt_sel_reg == GNT_B && fifo_empty[REQ_B_IDX]) pop_sel = GNT_A;
  end

  // Next-state and request/pop decode
  always_comb begin
    state_next   = state_reg;
    gnt_sel_next = gnt_sel_reg;
    o_req_valid  = 1'b0;
    o_req_bus    = 2'b00;
    pop_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rst && i_en && (fifo_empty != 2'b11)) begin
          o_req_valid          = 1'b1;
          o_req_bus[REQ_A_IDX] = !fifo_empty[REQ_A_IDX];
          o_req_bus[REQ_B_IDX] = !fifo_empty[REQ_B_IDX];
          state_next           = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (i_grant_valid) begin
          gnt_sel_next = i_grant_b;
          state_next   = ST_POP;
        end else begin
          state_next   = ST_IDLE;
        end
      end
      ST_POP: begin
        if (out_free) begin
          pop_en     = (fifo_empty != 2'b11);
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fifo_pop[REQ_A_IDX] = pop_en && (pop_sel == GNT_A);
  assign fifo_pop[REQ_B_IDX] = pop_en && (pop_sel == GNT_B);

  // FSM state and captured grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      gnt_sel_reg <= GNT_A;
    end else begin
      state_reg   <= state_next;
      gnt_sel_reg <= gnt_sel_next;
    end
  end

  // Output stage: load on pop, hold under backpressure, drain on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_reg  <= '0;
      o_valid_reg <= 1'b0;
    end else if (pop_en) begin
      o_data_reg  <= (pop_sel == GNT_B) ? fifo_rdata[REQ_B_IDX] : fifo_rdata[REQ_A_IDX];
      o_valid_reg <= 1'b1;
    end else if (i_ready) begin
      o_valid_reg <= 1'b0;
    end
  end

  assign o_data  = o_data_reg;
  assign o_valid = o_valid_reg;

`ifdef ARB_MERGE_STATS_EN
  logic [15:0] cnt_a_reg;
  logic [15:0] cnt_b_reg;

  // Forwarded-beat counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else begin
      if (fifo_pop[REQ_A_IDX]) cnt_a_reg <= cnt_a_reg + 16'd1;
      if (fifo_pop[REQ_B_IDX]) cnt_b_reg <= cnt_b_reg + 16'd1;
    end
  end

  assign o_cnt_a = cnt_a_reg;
  assign o_cnt_b = cnt_b_reg;
`endif

endmodule

// File: tb/tb_arb_merge_2to1.sv
// Testbench for arb_merge_2to1: model arbiter, output scoreboard, a table of
// single-beat transactions and hand-written multi-cycle sequences.
module tb_arb_merge_2to1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic [31:0] i_data_a = '0;
  logic        i_valid_a = 1'b0;
  logic        o_ready_a;
  logic [31:0] i_data_b = '0;
  logic        i_valid_b = 1'b0;
  logic        o_ready_b;
  logic [1:0]  o_req_bus;
  logic        o_req_valid;
  logic        grant_b;
  logic        grant_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready = 1'b1;

  // model arbiter state
  logic        model_gv = 1'b0;
  logic        model_gb = 1'b0;
  logic        model_g;
  logic        last_b = 1'b1;
  logic        arb_on = 1'b1;
  logic        late_gv = 1'b0;
  int          arb_mode = 0;   // 0 alternate, 1 force A, 2 force B

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [1:0]  req_q [$];

  always #5 clk = ~clk;

  assign grant_valid = model_gv | late_gv;
  assign grant_b     = late_gv ? 1'b0 : model_gb;

  arb_merge_2to1 #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_data_a      (i_data_a),
    .i_valid_a     (i_valid_a),
    .o_ready_a     (o_ready_a),
    .i_data_b      (i_data_b),
    .i_valid_b     (i_valid_b),
    .o_ready_b     (o_ready_b),
    .o_req_bus     (o_req_bus),
    .o_req_valid   (o_req_valid),
    .i_grant_b     (grant_b),
    .i_grant_valid (grant_valid),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Last-served arbiter model: registered grant one cycle after the request
  always @(posedge clk) begin
    if (rst) begin
      model_gv <= 1'b0;
      model_gb <= 1'b0;
      last_b   <= 1'b1;
    end else begin
      model_gv <= o_req_valid && arb_on;
      if (o_req_valid) begin
        case (arb_mode)
          0:       model_g = (o_req_bus == 2'b11) ? !last_b : o_req_bus[1];
          1:       model_g = 1'b0;
          default: model_g = 1'b1;
        endcase
        model_gb <= model_g;
        last_b   <= model_g;
      end
    end
  end

  // Request log and output scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (o_req_valid) req_q.push_back(o_req_bus);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected actual=%h required=none", o_data);
        end else begin
          chk("sb_data", o_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    req_q.delete();
  endtask

  task automatic push_beat(input bit use_b, input logic [31:0] d);
    if (use_b) begin i_data_b = d; i_valid_b = 1'b1; end
    else       begin i_data_a = d; i_valid_a = 1'b1; end
    @(posedge clk); #1;
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    bit          use_b;
    logic [31:0] data;
    int          mode;
    logic [1:0]  exp_bus;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    int c;

    vecs[0] = '{1'b0, 32'hA5A5A5A5, 1, 2'b01, 32'hA5A5A5A5, 3};
    vecs[1] = '{1'b1, 32'h0000BEEF, 1, 2'b10, 32'h0000BEEF, 3};  // stale grant
    vecs[2] = '{1'b1, 32'h12345678, 2, 2'b10, 32'h12345678, 3};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 2, 2'b01, 32'hFFFFFFFF, 3};  // stale grant
    vecs[4] = '{1'b0, 32'h00C0FFEE, 0, 2'b01, 32'h00C0FFEE, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_req_valid", {31'd0, o_req_valid}, 32'd0);
    chk("rst_req_bus", {30'd0, o_req_bus}, 32'd0);
    chk("rst_ready_a", {31'd0, o_ready_a}, 32'd1);
    chk("rst_ready_b", {31'd0, o_ready_b}, 32'd1);

    // Table: one beat per transaction with a fixed or alternating grant
    for (int v = 0; v < 5; v++) begin
      do_reset();
      arb_mode = vecs[v].mode;
      i_en     = 1'b1;
      i_ready  = 1'b1;
      exp_q.push_back(vecs[v].exp_data);
      push_beat(vecs[v].use_b, vecs[v].data);
      lat = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (o_valid) break;
        lat++;
      end
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      wait_drain($sformatf("v%0d_drain", v), 20);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_req_count", v), req_q.size(), 1);
      chk($sformatf("v%0d_req_bus", v), {30'd0, req_q[0]}, {30'd0, vecs[v].exp_bus});
      chk($sformatf("v%0d_ready_a", v), {31'd0, o_ready_a}, 32'd1);
    end

    // A and B loaded together, alternating grants
    do_reset();
    arb_mode = 0;
    i_en = 1'b0;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    i_data_b = 32'h2; i_valid_b = 1'b1;
    push_beat(1'b0, 32'h1);
    i_en = 1'b1;
    wait_drain("ab_drain", 40);
    repeat (4) @(negedge clk);
    chk("ab_req_count", req_q.size(), 2);
    chk("ab_req0_bus", {30'd0, req_q[0]}, 32'd3);
    chk("ab_req1_bus", {30'd0, req_q[1]}, 32'd2);

    // Backpressure with both buffers full
    do_reset();
    arb_mode = 0;
    i_en     = 1'b0;
    i_ready  = 1'b0;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h21);
    i_data_b = 32'h20; i_valid_b = 1'b1;
    push_beat(1'b0, 32'h10);
    i_data_b = 32'h21; i_valid_b = 1'b1;
    push_beat(1'b0, 32'h11);
    @(negedge clk);
    chk("bp_ready_a_full", {31'd0, o_ready_a}, 32'd0);
    chk("bp_ready_b_full", {31'd0, o_ready_b}, 32'd0);
    @(posedge clk); #1;
    i_en = 1'b1;
    c = 0;
    while (!o_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_first_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_first_data", o_data, 32'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), {31'd0, o_valid}, 32'd1);
      chk($sformatf("bp_hold_data%0d", k), o_data, 32'h10);
    end
    chk("bp_stall_req_count", req_q.size(), 2);
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_drain("bp_drain", 60);
    repeat (6) @(negedge clk);
    chk("bp_req_count", req_q.size(), 4);

    // Reset while waiting for a grant, followed by a late grant
    do_reset();
    arb_mode = 0;
    arb_on   = 1'b0;
    i_en     = 1'b0;
    i_data_b = 32'h32; i_valid_b = 1'b1;
    push_beat(1'b0, 32'h31);
    i_en = 1'b1;
    c = 0;
    while (!o_req_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("mr_req_seen", {31'd0, o_req_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    late_gv = 1'b1;
    @(negedge clk);
    chk("mr_o_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_ready_a", {31'd0, o_ready_a}, 32'd1);
    chk("mr_ready_b", {31'd0, o_ready_b}, 32'd1);
    chk("mr_req_valid", {31'd0, o_req_valid}, 32'd0);
    @(posedge clk); #1;
    late_gv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mr_idle_valid%0d", k), {31'd0, o_valid}, 32'd0);
      chk($sformatf("mr_idle_req%0d", k), {31'd0, o_req_valid}, 32'd0);
    end
    arb_on = 1'b1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
